float_dispatch: RTL and testbench

- Sequencer directly downstream of the floating-point opcode decoder.
- Accepts one decoded FP instruction at a time through a valid/ready handshake.
- For memory-operand forms (add_m, sub_m, div_m), fetches the operand over a simple req/ack read port.
- Issues the operation to the FP execution unit and holds off new instructions until that unit reports completion.

---
 rtl/float_dispatch_if.sv | 46 ++++
 rtl/float_dispatch.sv | 155 +++++++++++++++
 tb/tb_float_dispatch.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/float_dispatch_if.sv
// Handshake/bus bundle between the FP dispatcher, decoder, operand memory and execution unit.
// mem_err_o exists only when FLOAT_DISPATCH_MEM_TIMEOUT_EN is defined.
interface float_dispatch_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
);
    logic              op_valid_i;
    logic              op_ready_o;
    logic [8:0]        dec_i;
    logic [ADDR_W-1:0] addr_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;
    logic              ex_valid_o;
    logic              ex_ready_i;
    logic [2:0]        ex_op_o;
    logic              ex_mem_o;
    logic [DATA_W-1:0] ex_opnd_o;
    logic              ex_done_i;
    logic              illegal_o;
    logic              multi_o;
    logic [CNT_W-1:0]  done_cnt_o;
`ifdef FLOAT_DISPATCH_MEM_TIMEOUT_EN
    logic              mem_err_o;
`endif

    modport master (
        input  op_valid_i, dec_i, addr_i, mem_ack_i, mem_data_i, ex_ready_i, ex_done_i,
        output op_ready_o, mem_req_o, mem_addr_o, ex_valid_o, ex_op_o, ex_mem_o,
               ex_opnd_o, illegal_o, multi_o, done_cnt_o
`ifdef FLOAT_DISPATCH_MEM_TIMEOUT_EN
        , output mem_err_o
`endif
    );

    modport slave (
        output op_valid_i, dec_i, addr_i, mem_ack_i, mem_data_i, ex_ready_i, ex_done_i,
        input  op_ready_o, mem_req_o, mem_addr_o, ex_valid_o, ex_op_o, ex_mem_o,
               ex_opnd_o, illegal_o, multi_o, done_cnt_o
`ifdef FLOAT_DISPATCH_MEM_TIMEOUT_EN
        , input mem_err_o
`endif
    );
endinterface

// File: rtl/float_dispatch.sv
// FP instruction sequencer: accept decoded op, fetch memory operand, issue, wait for completion.
// Optional MEM-phase abort on missing ack: define FLOAT_DISPATCH_MEM_TIMEOUT_EN.
module float_dispatch #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst,
    float_dispatch_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_MEM, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            r_state;
    logic              r_op_ready;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_ex_valid;
    logic [2:0]        r_ex_op;
    logic              r_ex_mem;
    logic [DATA_W-1:0] r_ex_opnd;
    logic              r_illegal;
    logic              r_multi;
    logic [CNT_W-1:0]  r_done_cnt;

    logic [2:0]        w_op;
    logic              w_mem;
    logic              w_none;
    logic              w_multi;

`ifdef FLOAT_DISPATCH_MEM_TIMEOUT_EN
    localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_mem_err;
    assign bus.mem_err_o = r_mem_err;
`endif

    // Lowest flag bit has highest priority; add/sub pairs share an opcode.
    always_comb begin
        w_op  = 3'd0;
        w_mem = 1'b0;
        if      (bus.dec_i[0]) w_op = 3'd0;
        else if (bus.dec_i[1]) w_op = 3'd1;
        else if (bus.dec_i[2]) begin w_op = 3'd1; w_mem = 1'b1; end
        else if (bus.dec_i[3]) w_op = 3'd2;
        else if (bus.dec_i[4]) begin w_op = 3'd2; w_mem = 1'b1; end
        else if (bus.dec_i[5]) w_op = 3'd3;
        else if (bus.dec_i[6]) w_op = 3'd4;
        else if (bus.dec_i[7]) begin w_op = 3'd5; w_mem = 1'b1; end
        else if (bus.dec_i[8]) w_op = 3'd6;
    end

    assign w_none  = (bus.dec_i == '0);
    assign w_multi = ((bus.dec_i & (bus.dec_i - 9'd1)) != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op_ready <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_mem   <= 1'b0;
            r_ex_opnd  <= '0;
            r_illegal  <= 1'b0;
            r_multi    <= 1'b0;
            r_done_cnt <= '0;
`ifdef FLOAT_DISPATCH_MEM_TIMEOUT_EN
            r_tmo      <= '0;
            r_mem_err  <= 1'b0;
`endif
        end else begin
            r_illegal <= 1'b0;
            r_multi   <= 1'b0;
`ifdef FLOAT_DISPATCH_MEM_TIMEOUT_EN
            r_mem_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // op_ready is low only on the first cycle out of reset.
                    if (!r_op_ready) begin
                        r_op_ready <= 1'b1;
                    end else if (bus.op_valid_i) begin
                        if (w_none) begin
                            r_illegal <= 1'b1;
                        end else begin
                            r_op_ready <= 1'b0;
                            r_multi    <= w_multi;
                            r_ex_op    <= w_op;
                            r_ex_mem   <= w_mem;
                            r_ex_opnd  <= '0;
                            if (w_mem) begin
                                r_mem_req  <= 1'b1;
                                r_mem_addr <= bus.addr_i;
`ifdef FLOAT_DISPATCH_MEM_TIMEOUT_EN
                                r_tmo      <= '0;
`endif
                                r_state    <= S_MEM;
                            end else begin
                                r_ex_valid <= 1'b1;
                                r_state    <= S_ISSUE;
                            end
                        end
                    end
                end
                S_MEM: begin
                    if (bus.mem_ack_i) begin
                        r_ex_opnd  <= bus.mem_data_i;
                        r_mem_req  <= 1'b0;
                        r_ex_valid <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
`ifdef FLOAT_DISPATCH_MEM_TIMEOUT_EN
                    else if (r_tmo == TMO_W'(MEM_TIMEOUT - 1)) begin
                        r_mem_req  <= 1'b0;
                        r_mem_err  <= 1'b1;
                        r_op_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                S_ISSUE: begin
                    if (bus.ex_ready_i) begin
                        r_ex_valid <= 1'b0;
                        r_state    <= bus.ex_done_i ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.ex_done_i) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done_cnt <= r_done_cnt + 1'b1;
                    r_op_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.op_ready_o = r_op_ready;
    assign bus.mem_req_o  = r_mem_req;
    assign bus.mem_addr_o = r_mem_addr;
    assign bus.ex_valid_o = r_ex_valid;
    assign bus.ex_op_o    = r_ex_op;
    assign bus.ex_mem_o   = r_ex_mem;
    assign bus.ex_opnd_o  = r_ex_opnd;
    assign bus.illegal_o  = r_illegal;
    assign bus.multi_o    = r_multi;
    assign bus.done_cnt_o = r_done_cnt;
endmodule

// File: tb/tb_float_dispatch.sv
// Directed + randomized bench for float_dispatch against a flag-table reference model.
module tb_float_dispatch;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned exp_cnt = 0;

    // Opcode and memory-operand flag for each decoder bit, bit 0 first (highest priority).
    int unsigned op_of_bit [9] = '{0, 1, 1, 2, 2, 3, 4, 5, 6};
    bit          mem_of_bit[9] = '{0, 0, 1, 0, 1, 0, 0, 1, 0};

    float_dispatch_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

    float_dispatch #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic model(input logic [8:0] dec, output int unsigned op, output bit mem,
                         output bit ill, output bit mul);
        int unsigned n;
        n = 0; op = 0; mem = 0;
        for (int i = 8; i >= 0; i--) begin
            if (dec[i]) begin
                op  = op_of_bit[i];
                mem = mem_of_bit[i];
                n++;
            end
        end
        ill = (n == 0);
        mul = (n > 1);
    endtask

    task automatic do_op(input logic [8:0] dec, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int unsigned ack_dly, input int unsigned rdy_dly, input int unsigned done_dly);
        int unsigned eop;
        bit emem, eill, emul;
        model(dec, eop, emem, eill, emul);
        chk("ready_before_accept", bus.op_ready_o, 1'b1);
        bus.op_valid_i = 1'b1;
        bus.dec_i      = dec;
        bus.addr_i     = addr;
        cyc();
        bus.op_valid_i = 1'b0;
        bus.dec_i      = 9'($urandom);
        bus.addr_i     = AW'($urandom);
        chk("illegal_pulse", bus.illegal_o, eill);
        chk("multi_pulse", bus.multi_o, emul);
        if (eill) begin
            chk("illegal_no_req", bus.mem_req_o, 1'b0);
            chk("illegal_no_issue", bus.ex_valid_o, 1'b0);
            chk("illegal_ready", bus.op_ready_o, 1'b1);
            cyc();
            chk("illegal_one_cycle", bus.illegal_o, 1'b0);
            chk("illegal_cnt", bus.done_cnt_o, 64'(exp_cnt % (1 << CW)));
            return;
        end
        if (emem) begin
            for (int k = 0; k <= int'(ack_dly); k++) begin
                chk("mem_req", bus.mem_req_o, 1'b1);
                chk("mem_addr", bus.mem_addr_o, addr);
                chk("mem_no_issue", bus.ex_valid_o, 1'b0);
                bus.mem_ack_i  = (k == int'(ack_dly));
                bus.mem_data_i = (k == int'(ack_dly)) ? data : {$urandom, $urandom};
                bus.ex_done_i  = 1'($urandom);
                cyc();
                if (k != int'(ack_dly)) chk("multi_one_cycle", bus.multi_o, 1'b0);
            end
            bus.mem_ack_i  = 1'b0;
            bus.mem_data_i = {$urandom, $urandom};
        end
        for (int k = 0; k <= int'(rdy_dly); k++) begin
            chk("ex_valid", bus.ex_valid_o, 1'b1);
            chk("ex_op", bus.ex_op_o, 64'(eop));
            chk("ex_mem", bus.ex_mem_o, emem);
            chk("ex_opnd", bus.ex_opnd_o, emem ? data : 64'd0);
            chk("issue_no_req", bus.mem_req_o, 1'b0);
            chk("issue_not_ready", bus.op_ready_o, 1'b0);
            bus.ex_ready_i = (k == int'(rdy_dly));
            bus.ex_done_i  = (k == int'(rdy_dly)) && (done_dly == 0);
            bus.mem_ack_i  = 1'($urandom);
            cyc();
        end
        for (int k = 1; k <= int'(done_dly); k++) begin
            chk("wait_no_valid", bus.ex_valid_o, 1'b0);
            chk("wait_not_ready", bus.op_ready_o, 1'b0);
            chk("wait_opnd_held", bus.ex_opnd_o, emem ? data : 64'd0);
            bus.ex_ready_i = 1'($urandom);
            bus.ex_done_i  = (k == int'(done_dly));
            cyc();
        end
        bus.mem_ack_i = 1'b0;
        chk("done_not_ready", bus.op_ready_o, 1'b0);
        chk("done_no_valid", bus.ex_valid_o, 1'b0);
        cyc();
        exp_cnt++;
        chk("ready_after_done", bus.op_ready_o, 1'b1);
        chk("done_cnt", bus.done_cnt_o, 64'(exp_cnt % (1 << CW)));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_op_ready"}, bus.op_ready_o, 1'b0);
        chk({tag, "_mem_req"}, bus.mem_req_o, 1'b0);
        chk({tag, "_mem_addr"}, bus.mem_addr_o, '0);
        chk({tag, "_ex_valid"}, bus.ex_valid_o, 1'b0);
        chk({tag, "_ex_op"}, bus.ex_op_o, '0);
        chk({tag, "_ex_mem"}, bus.ex_mem_o, 1'b0);
        chk({tag, "_ex_opnd"}, bus.ex_opnd_o, '0);
        chk({tag, "_illegal"}, bus.illegal_o, 1'b0);
        chk({tag, "_multi"}, bus.multi_o, 1'b0);
        chk({tag, "_done_cnt"}, bus.done_cnt_o, '0);
    endtask

    initial begin
        logic [8:0] d;
        bus.op_valid_i = 1'b0;
        bus.dec_i      = '0;
        bus.addr_i     = '0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        bus.ex_ready_i = 1'b1;
        bus.ex_done_i  = 1'b1;
        cyc();
        cyc();
        check_all_zero("reset");
        rst = 1'b0;
        cyc();
        chk("ready_rises", bus.op_ready_o, 1'b1);

        do_op(9'h001, 16'h0000, 64'd0, 0, 0, 0);
        do_op(9'h004, 16'h1234, 64'hDEAD_BEEF, 2, 0, 0);
        do_op(9'h000, 16'h0000, 64'd0, 0, 0, 0);
        do_op(9'h011, 16'h0000, 64'd0, 0, 0, 0);
        do_op(9'h040, 16'h0000, 64'd0, 0, 5, 4);
        do_op(9'h080, 16'hBEEF, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
        do_op(9'h100, 16'h0000, 64'd0, 0, 1, 2);

`ifdef FLOAT_DISPATCH_MEM_TIMEOUT_EN
        chk("tmo_ready", bus.op_ready_o, 1'b1);
        bus.op_valid_i = 1'b1;
        bus.dec_i      = 9'h010;
        bus.addr_i     = 16'h00AA;
        cyc();
        bus.op_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("tmo_req", bus.mem_req_o, 1'b1);
            chk("tmo_no_err", bus.mem_err_o, 1'b0);
            cyc();
        end
        chk("tmo_err", bus.mem_err_o, 1'b1);
        chk("tmo_req_drop", bus.mem_req_o, 1'b0);
        chk("tmo_ready", bus.op_ready_o, 1'b1);
        chk("tmo_no_issue", bus.ex_valid_o, 1'b0);
        cyc();
        chk("tmo_err_one_cycle", bus.mem_err_o, 1'b0);
        chk("tmo_cnt", bus.done_cnt_o, 64'(exp_cnt % (1 << CW)));
        do_op(9'h010, 16'h00AB, 64'h5555_AAAA, 3, 0, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       d = 9'h000;
                1:       d = 9'(1 << $urandom_range(0, 8));
                default: d = 9'($urandom);
            endcase
            do_op(d, AW'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        chk("cnt_after_wraps", bus.done_cnt_o, 64'(exp_cnt % (1 << CW)));

        bus.op_valid_i = 1'b1;
        bus.dec_i      = 9'h002;
        cyc();
        bus.op_valid_i = 1'b0;
        bus.ex_ready_i = 1'b1;
        bus.ex_done_i  = 1'b0;
        chk("rst_pre_valid", bus.ex_valid_o, 1'b1);
        cyc();
        chk("rst_pre_wait", bus.ex_valid_o, 1'b0);
        cyc();
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        cyc();
        rst = 1'b0;
        exp_cnt = 0;
        bus.ex_done_i = 1'b1;
        cyc();
        chk("post_rst_ready", bus.op_ready_o, 1'b1);
        do_op(9'h020, 16'h0000, 64'd0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
